cpu_sequencer: RTL
==================

# cpu_sequencer

Multi-cycle control sequencer for the 8-bit accumulator-free datapath (program counter, 2-byte instruction fetch, 4-entry register file, ALU, data memory, output port). It replaces the single-cycle combinational controller. It fetches each 2-byte instruction over a shared byte-wide memory port using a req/ack handshake, then drives the datapath write enables and mux selects state by state. It also counts retired instructions.

## Interface

- COUNT_WIDTH, 16, width of retired-instruction counter (saturating)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  1 = start/continue execution; sampled at instruction boundaries
- mem_ack  in  1  memory transfer complete; meaningful only while mem_req=1
- ir_op  in  4  opcode field of instruction register byte 0
- ir_ra  in  2  ra field of byte 0 (destination register / branch condition)
- flag_n, flag_z  in  1 each  negative / zero flags from register file
- mem_req  out  1  memory transfer request
- mem_sel  out  2  address source: 00 PC, 01 PC+1, 10 ea (data)
- mem_we  out  1  memory write (store)
- ir0_we, ir1_we  out  1 each  load instruction byte 0 / byte 1
- pc_we  out  1  program counter update
- branch_sel  out  2  next PC: 00 PC+2, 01 ea, 10 LR
- lr_we  out  1  link register load (PC+2)
- rf_we  out  4  one-hot register write enable, index = ir_ra
- wb_sel  out  1  writeback source: 0 ALU, 1 memory
- port_sel  out  1  ALU B operand: 0 rb, 1 in_port
- alu_op  out  4  ALU operation (= ir_op in EX)
- out_we  out  1  output port load
- halted  out  1  HALT state indicator
- retired  out  COUNT_WIDTH  retired-instruction count

## Operation

- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 NAND, 4 SHL, 5 SHR, 6 IN, 7 OUT, 8 MOV, 9 LOAD, A STORE, B LOADI, C BR, D BRL, E RET, F HALT.
- States: IDLE, F0, F1, EX, MEM, WB, HALT. All outputs are decoded from state plus inputs. Unlisted outputs are 0.
- IDLE: when run=1, go to F0.
- F0: mem_req=1, mem_sel=00, ir0_we=mem_ack. On ack, go to F1.
- F1: mem_req=1, mem_sel=01, ir1_we=mem_ack. On ack, go to EX.
- EX (single cycle), by opcode:
  - Ops 1–6, 8, B: rf_we[ir_ra]=1, wb_sel=0, alu_op=ir_op, port_sel=(op==6), pc_we=1, branch_sel=00.
  - OUT: out_we=1, alu_op=7, pc_we=1.
  - NOP: pc_we=1.
  - LOAD / STORE: no pc_we; go to MEM.
  - BR: condition from ir_ra: 00 always, 01 Z, 10 N, 11 !Z. pc_we=1; branch_sel=01 if taken, else 00.
  - BRL: lr_we=1, pc_we=1, branch_sel=01.
  - RET: pc_we=1, branch_sel=10.
  - HALT: go to HALT; no pc_we.
- MEM: mem_req=1, mem_sel=10, mem_we=(op==A).
  - On ack with STORE: pc_we=1, then boundary.
  - On ack with LOAD: go to WB.
- WB: rf_we[ir_ra]=1, wb_sel=1, pc_we=1, then boundary.
- Boundary: next state is F0 if run=1, else IDLE.
- HALT: halted=1. Exit is by reset only; run is ignored.
- retired increments by 1 on every cycle with pc_we=1 and on HALT entry. It holds at all-ones (no wrap).

## Timing

- Reset (async, immediate): state=IDLE, retired=0. All outputs are 0, including mem_req mid-handshake.
- Handshake:
  - A transfer completes at a rising edge with mem_req=1 and mem_ack=1.
  - mem_sel and mem_we stay stable while mem_req=1.
  - mem_ack is ignored in IDLE, EX, WB and HALT.
  - mem_req may stay high back-to-back across F0→F1.
- Latency with zero-wait memory (ack same cycle as req):
  - ALU, branch, OUT, NOP: 3 cycles (F0, F1, EX).
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- run is sampled only at boundaries and in IDLE. Deasserting run mid-instruction completes the instruction, then enters IDLE. IDLE→F0 takes 1 cycle after run=1.
- Write enables (rf_we, pc_we, lr_we, out_we) pulse exactly one cycle per instruction.
- rf_we is never asserted together with mem_req.

## Test plan

- Reset mid-fetch: assert rst_n=0 while F0 waits on ack → mem_req=0 immediately, retired=0. After release with run=1 → F0 next cycle.
- ADD with ir_ra=2, mem_ack tied 1 → mem_req high 2 cycles, then rf_we=0100, pc_we=1, branch_sel=00 in cycle 3. retired=1.
- LOAD ir_ra=1, ack delayed 2 cycles in MEM → mem_sel=10, mem_we=0 held through the wait. WB cycle has rf_we=0010, wb_sel=1. Total 7 cycles.
- BR cond=01 with flag_z=0 → branch_sel=00; with flag_z=1 → branch_sel=01. BRL → lr_we=1 and branch_sel=01 in the same cycle. RET → branch_sel=10.
- run dropped during F1 of an OUT → out_we pulse occurs, then IDLE with no further mem_req. run=1 again → F0 next cycle.
- HALT, then toggle run → halted=1 stays, no mem_req. Preload retired to all-ones at COUNT_WIDTH=4, execute NOP → retired stays 0xF.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: fetches a 2-byte instruction over a req/ack byte port,
// then steps the datapath through EX / MEM / WB and counts retired instructions.
module cpu_sequencer #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   mem_ack,
    input  logic [3:0]             ir_op,
    input  logic [1:0]             ir_ra,
    input  logic                   flag_n,
    input  logic                   flag_z,
    output logic                   mem_req,
    output logic [1:0]             mem_sel,
    output logic                   mem_we,
    output logic                   ir0_we,
    output logic                   ir1_we,
    output logic                   pc_we,
    output logic [1:0]             branch_sel,
    output logic                   lr_we,
    output logic [3:0]             rf_we,
    output logic                   wb_sel,
    output logic                   port_sel,
    output logic [3:0]             alu_op,
    output logic                   out_we,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_F0, S_F1, S_EX, S_MEM, S_WB, S_HALT
    } state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] retired_q, retired_d;
    logic                   taken;
    logic                   halt_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_F0;
            S_F0:   if (mem_ack) state_d = S_F1;
            S_F1:   if (mem_ack) state_d = S_EX;
            S_EX: begin
                case (ir_op)
                    4'h9, 4'hA: state_d = S_MEM;
                    4'hF:       state_d = S_HALT;
                    default:    state_d = run ? S_F0 : S_IDLE;
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (ir_op == 4'hA) state_d = run ? S_F0 : S_IDLE;
                    else               state_d = S_WB;
                end
            end
            S_WB:    state_d = run ? S_F0 : S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Branch condition encoded in ra: always, Z, N, !Z.
    always_comb begin
        taken = 1'b0;
        case (ir_ra)
            2'b00: taken = 1'b1;
            2'b01: taken = flag_z;
            2'b10: taken = flag_n;
            2'b11: taken = !flag_z;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_sel    = 2'b00;
        mem_we     = 1'b0;
        ir0_we     = 1'b0;
        ir1_we     = 1'b0;
        pc_we      = 1'b0;
        branch_sel = 2'b00;
        lr_we      = 1'b0;
        rf_we      = 4'b0000;
        wb_sel     = 1'b0;
        port_sel   = 1'b0;
        alu_op     = 4'h0;
        out_we     = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_F0: begin
                mem_req = 1'b1;
                mem_sel = 2'b00;
                ir0_we  = mem_ack;
            end
            S_F1: begin
                mem_req = 1'b1;
                mem_sel = 2'b01;
                ir1_we  = mem_ack;
            end
            S_EX: begin
                case (ir_op)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'hB: begin
                        rf_we    = 4'b0001 << ir_ra;
                        alu_op   = ir_op;
                        port_sel = (ir_op == 4'h6);
                        pc_we    = 1'b1;
                    end
                    4'h7: begin
                        out_we = 1'b1;
                        alu_op = 4'h7;
                        pc_we  = 1'b1;
                    end
                    4'h0: pc_we = 1'b1;
                    4'hC: begin
                        pc_we      = 1'b1;
                        branch_sel = taken ? 2'b01 : 2'b00;
                    end
                    4'hD: begin
                        lr_we      = 1'b1;
                        pc_we      = 1'b1;
                        branch_sel = 2'b01;
                    end
                    4'hE: begin
                        pc_we      = 1'b1;
                        branch_sel = 2'b10;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 2'b10;
                mem_we  = (ir_op == 4'hA);
                pc_we   = mem_ack && (ir_op == 4'hA);
            end
            S_WB: begin
                rf_we  = 4'b0001 << ir_ra;
                wb_sel = 1'b1;
                pc_we  = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    // HALT retires on entry even though it never updates the PC.
    assign halt_entry = (state_q == S_EX) && (ir_op == 4'hF);

    always_comb begin
        retired_d = retired_q;
        if ((pc_we || halt_entry) && (retired_q != {COUNT_WIDTH{1'b1}}))
            retired_d = retired_q + 1'b1;
    end

    assign retired = retired_q;

endmodule
